// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control path:
// FSM states, opcodes, immediate formats, ALU operations and datapath mux selects.
package ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH,
        JAL,
        JALR,
        LUI,
        TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_fmt_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_ctrl_t;

    // Fixed ADD/SUB for address and compare states, funct-driven for execute states.
    typedef enum logic [1:0] {
        ALU_CLS_ADD,
        ALU_CLS_SUB,
        ALU_CLS_FUNCT
    } alu_class_t;

    localparam logic [1:0] SRC_A_PC     = 2'd0;
    localparam logic [1:0] SRC_A_OLD_PC = 2'd1;
    localparam logic [1:0] SRC_A_RS1    = 2'd2;

    localparam logic [1:0] SRC_B_RS2    = 2'd0;
    localparam logic [1:0] SRC_B_IMM    = 2'd1;
    localparam logic [1:0] SRC_B_FOUR   = 2'd2;

    localparam logic [1:0] RES_ALU_OUT  = 2'd0;
    localparam logic [1:0] RES_MEM      = 2'd1;
    localparam logic [1:0] RES_ALU      = 2'd2;
    localparam logic [1:0] RES_IMM      = 2'd3;

    function automatic imm_fmt_t imm_fmt_of(input logic [6:0] opcode);
        imm_fmt_t fmt;
        case (opcode)
            OP_STORE:         fmt = IMM_S;
            OP_BRANCH:        fmt = IMM_B;
            OP_LUI, OP_AUIPC: fmt = IMM_U;
            OP_JAL:           fmt = IMM_J;
            default:          fmt = IMM_I;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the control state class plus funct3/funct7[5] to an ALU operation.
// Only register ops may select SUB; funct7[5] on op-imm is honoured for SRAI alone.
module alu_decoder
    import ctrl_pkg::*;
(
    input  alu_class_t alu_class,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       op_imm,
    output alu_ctrl_t  alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        case (alu_class)
            ALU_CLS_SUB: alu_op = ALU_SUB;
            ALU_CLS_FUNCT: begin
                case (funct3)
                    3'b000:  alu_op = (funct7_5 && !op_imm) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_op = ALU_SLL;
                    3'b010:  alu_op = ALU_SLT;
                    3'b011:  alu_op = ALU_SLTU;
                    3'b100:  alu_op = ALU_XOR;
                    3'b101:  alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
            end
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core (fetch/decode/execute/memory/writeback).
// Build option ICYRISC_CTRL_TRAP_EN: illegal opcodes halt in TRAP instead of retiring as NOPs.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int IMM_CTRL_W = 3,
    parameter int ALU_CTRL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           instr,
    input  logic                  mem_ready,
    input  logic                  branch_taken,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  adr_src,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  reg_write,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic [1:0]            result_src,
    output logic [IMM_CTRL_W-1:0] imm_ctrl,
    output logic                  halted,
    output state_t                state_dbg
);

    state_t     state, state_next;
    logic       jalr_phase, jalr_phase_next;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       is_store;
    alu_class_t alu_cls;
    alu_ctrl_t  alu_op;
    imm_fmt_t   imm_sel;
    logic       unused_instr_bits;

    assign opcode            = instr[6:0];
    assign funct3            = instr[14:12];
    assign funct7_5          = instr[30];
    assign is_store          = (opcode == OP_STORE);
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            jalr_phase <= 1'b0;
        end else begin
            state      <= state_next;
            jalr_phase <= jalr_phase_next;
        end
    end

    always_comb begin
        state_next      = state;
        jalr_phase_next = 1'b0;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        adr_src         = 1'b0;
        ir_write        = 1'b0;
        pc_write        = 1'b0;
        reg_write       = 1'b0;
        alu_src_a       = SRC_A_PC;
        alu_src_b       = SRC_B_RS2;
        result_src      = RES_ALU_OUT;
        alu_cls         = ALU_CLS_ADD;
        imm_sel         = IMM_I;

        case (state)
            IDLE: state_next = FETCH;
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) state_next = DECODE;
            end
            // alu_out captures old_pc + imm for branch, jal and auipc targets.
            DECODE: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
                imm_sel   = imm_fmt_of(opcode);
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = MEMADR;
                    OP_OP:             state_next = EXECR;
                    OP_OP_IMM:         state_next = EXECI;
                    OP_BRANCH:         state_next = BRANCH;
                    OP_JAL:            state_next = JAL;
                    OP_JALR:           state_next = JALR;
                    OP_LUI:            state_next = LUI;
                    OP_AUIPC:          state_next = ALUWB;
                    default: begin
`ifdef ICYRISC_CTRL_TRAP_EN
                        state_next = TRAP;
`else
                        state_next = FETCH;
`endif
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                imm_sel    = is_store ? IMM_S : IMM_I;
                state_next = is_store ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_next = MEMWB;
            end
            MEMWB: begin
                result_src = RES_MEM;
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            MEMWRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_next = FETCH;
            end
            EXECR: begin
                alu_src_a  = SRC_A_RS1;
                alu_cls    = ALU_CLS_FUNCT;
                state_next = ALUWB;
            end
            // rs1 is the A operand of every op-imm instruction.
            EXECI: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                alu_cls    = ALU_CLS_FUNCT;
                state_next = ALUWB;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                alu_src_a  = SRC_A_RS1;
                alu_cls    = ALU_CLS_SUB;
                pc_write   = branch_taken;
                state_next = FETCH;
            end
            JAL: begin
                pc_write   = 1'b1;
                alu_src_a  = SRC_A_OLD_PC;
                alu_src_b  = SRC_B_FOUR;
                state_next = ALUWB;
            end
            // First visit computes rs1+imm; second jumps there and forms the link value.
            JALR: begin
                jalr_phase_next = ~jalr_phase;
                if (!jalr_phase) begin
                    alu_src_a  = SRC_A_RS1;
                    alu_src_b  = SRC_B_IMM;
                    state_next = JALR;
                end else begin
                    pc_write   = 1'b1;
                    alu_src_a  = SRC_A_OLD_PC;
                    alu_src_b  = SRC_B_FOUR;
                    state_next = ALUWB;
                end
            end
            LUI: begin
                result_src = RES_IMM;
                imm_sel    = IMM_U;
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            TRAP:    state_next = TRAP;
            default: state_next = IDLE;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_class (alu_cls),
        .funct3    (funct3),
        .funct7_5  (funct7_5),
        .op_imm    (state == EXECI),
        .alu_op    (alu_op)
    );

    assign alu_ctrl  = ALU_CTRL_W'(alu_op);
    assign imm_ctrl  = IMM_CTRL_W'(imm_sel);
    assign state_dbg = state;

`ifdef ICYRISC_CTRL_TRAP_EN
    assign halted = (state == TRAP);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: an instruction-level model pushes the expected
// per-cycle control vector; a monitor pops and compares on every falling edge.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        mem_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, halted;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [3:0]  alu_ctrl;
  logic [2:0]  imm_ctrl;
  state_t      state_dbg;

  always #5 clk = ~clk;

  multicycle_ctrl #(.IMM_CTRL_W(3), .ALU_CTRL_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .adr_src      (adr_src),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .reg_write    (reg_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_ctrl     (alu_ctrl),
    .result_src   (result_src),
    .imm_ctrl     (imm_ctrl),
    .halted       (halted),
    .state_dbg    (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [19:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  string       cur_tag = "reset";

  localparam int C_LOAD = 0, C_STORE = 1, C_OP = 2, C_OPIMM = 3, C_BRANCH = 4;
  localparam int C_JAL = 5, C_JALR = 6, C_LUI = 7, C_AUIPC = 8, C_ILLEGAL = 9;

  // Expected vector: {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
  //                   alu_src_a, alu_src_b, alu_ctrl, result_src, imm_ctrl, halted}
  function automatic logic [19:0] pk(input logic mreq, input logic mwe, input logic adr,
                                     input logic irw, input logic pcw, input logic rw,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [3:0] alu, input logic [1:0] res,
                                     input logic [2:0] imm, input logic hlt);
    return {mreq, mwe, adr, irw, pcw, rw, a, b, alu, res, imm, hlt};
  endfunction

  function automatic int classify(input logic [6:0] op);
    case (op)
      7'h03:   return C_LOAD;
      7'h23:   return C_STORE;
      7'h33:   return C_OP;
      7'h13:   return C_OPIMM;
      7'h63:   return C_BRANCH;
      7'h6F:   return C_JAL;
      7'h67:   return C_JALR;
      7'h37:   return C_LUI;
      7'h17:   return C_AUIPC;
      default: return C_ILLEGAL;
    endcase
  endfunction

  function automatic logic [2:0] model_imm(input int cls);
    if (cls == C_STORE) return 3'd1;
    if (cls == C_BRANCH) return 3'd2;
    if (cls == C_LUI || cls == C_AUIPC) return 3'd3;
    if (cls == C_JAL) return 3'd4;
    return 3'd0;
  endfunction

  function automatic logic [3:0] model_alu(input logic [2:0] f3, input logic f7b, input bit is_imm);
    logic [3:0] tbl [8];
    tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    if (f7b && f3 == 3'd5) return ALU_SRA;
    if (f7b && f3 == 3'd0 && !is_imm) return ALU_SUB;
    return tbl[f3];
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input string tag, input logic [31:0] ins, input logic rdy,
                      input logic tk, input logic [19:0] e);
    @(posedge clk);
    #1;
    instr        = ins;
    mem_ready    = rdy;
    branch_taken = tk;
    cur_tag      = tag;
    exp_q.push_back(e);
  endtask

  task automatic run_instr(input string tag, input logic [31:0] ins, input int fw,
                           input int mw, input logic tk);
    int cls;
    logic [3:0] op;
    cls = classify(ins[6:0]);
    for (int i = 0; i < fw; i++)
      step(tag, ins, 1'b0, rbit(), pk(1,0,0,0,0,0, 2'd0,2'd2,ALU_ADD,2'd2,3'd0,0));
    step(tag, ins, 1'b1, rbit(), pk(1,0,0,1,1,0, 2'd0,2'd2,ALU_ADD,2'd2,3'd0,0));
    step(tag, ins, rbit(), rbit(), pk(0,0,0,0,0,0, 2'd1,2'd1,ALU_ADD,2'd0,model_imm(cls),0));
    case (cls)
      C_LOAD, C_STORE: begin
        step(tag, ins, rbit(), rbit(),
             pk(0,0,0,0,0,0, 2'd2,2'd1,ALU_ADD,2'd0,(cls == C_STORE) ? 3'd1 : 3'd0,0));
        for (int i = 0; i <= mw; i++)
          step(tag, ins, (i == mw), rbit(),
               pk(1,(cls == C_STORE),1,0,0,0, 2'd0,2'd0,ALU_ADD,2'd0,3'd0,0));
        if (cls == C_LOAD)
          step(tag, ins, rbit(), rbit(), pk(0,0,0,0,0,1, 2'd0,2'd0,ALU_ADD,2'd1,3'd0,0));
      end
      C_OP, C_OPIMM: begin
        op = model_alu(ins[14:12], ins[30], cls == C_OPIMM);
        step(tag, ins, rbit(), rbit(),
             pk(0,0,0,0,0,0, 2'd2,(cls == C_OPIMM) ? 2'd1 : 2'd0,op,2'd0,3'd0,0));
        step(tag, ins, rbit(), rbit(), pk(0,0,0,0,0,1, 2'd0,2'd0,ALU_ADD,2'd0,3'd0,0));
      end
      C_BRANCH:
        step(tag, ins, rbit(), tk, pk(0,0,0,0,tk,0, 2'd2,2'd0,ALU_SUB,2'd0,3'd0,0));
      C_JAL, C_JALR: begin
        if (cls == C_JALR)
          step(tag, ins, rbit(), rbit(), pk(0,0,0,0,0,0, 2'd2,2'd1,ALU_ADD,2'd0,3'd0,0));
        step(tag, ins, rbit(), rbit(), pk(0,0,0,0,1,0, 2'd1,2'd2,ALU_ADD,2'd0,3'd0,0));
        step(tag, ins, rbit(), rbit(), pk(0,0,0,0,0,1, 2'd0,2'd0,ALU_ADD,2'd0,3'd0,0));
      end
      C_LUI:
        step(tag, ins, rbit(), rbit(), pk(0,0,0,0,0,1, 2'd0,2'd0,ALU_ADD,2'd3,3'd3,0));
      C_AUIPC:
        step(tag, ins, rbit(), rbit(), pk(0,0,0,0,0,1, 2'd0,2'd0,ALU_ADD,2'd0,3'd0,0));
      default: begin
`ifdef ICYRISC_CTRL_TRAP_EN
        for (int i = 0; i < 4; i++)
          step(tag, ins, rbit(), rbit(), pk(0,0,0,0,0,0, 2'd0,2'd0,ALU_ADD,2'd0,3'd0,1));
`endif
      end
    endcase
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    cur_tag = "reset";
    exp_q.push_back('0);
    #1;
    check("reset_state_idle", 32'(state_dbg), 32'(IDLE));
    check("reset_halted", 32'(halted), 32'd0);
    @(posedge clk);
    #1;
    exp_q.push_back('0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back('0);
  endtask

  // Store stalls in MEMWRITE, then reset lands mid-cycle: request must vanish at once.
  task automatic store_reset();
    logic [31:0] sw;
    sw = 32'h0020A223;
    step("sw_rst", sw, 1'b1, 1'b0, pk(1,0,0,1,1,0, 2'd0,2'd2,ALU_ADD,2'd2,3'd0,0));
    step("sw_rst", sw, 1'b1, 1'b0, pk(0,0,0,0,0,0, 2'd1,2'd1,ALU_ADD,2'd0,3'd1,0));
    step("sw_rst", sw, 1'b1, 1'b0, pk(0,0,0,0,0,0, 2'd2,2'd1,ALU_ADD,2'd0,3'd1,0));
    step("sw_rst", sw, 1'b0, 1'b0, pk(1,1,1,0,0,0, 2'd0,2'd0,ALU_ADD,2'd0,3'd0,0));
    step("sw_rst", sw, 1'b0, 1'b0, pk(1,1,1,0,0,0, 2'd0,2'd0,ALU_ADD,2'd0,3'd0,0));
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_write_mem_req", 32'(mem_req), 32'd0);
    check("rst_mid_write_mem_we", 32'(mem_we), 32'd0);
    check("rst_mid_write_state", 32'(state_dbg), 32'(IDLE));
    step("sw_rst", sw, 1'b1, 1'b0, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back('0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  ops [9];
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    r = $urandom();
    r[6:0] = ops[$urandom_range(0, 8)];
    return r;
  endfunction

  // ---------------- monitor ----------------
  task automatic monitor();
    logic [19:0] e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
             alu_src_a, alu_src_b, alu_ctrl, result_src, imm_ctrl, halted};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s outputs: got %05h expected %05h (state %s)",
                   cur_tag, a, e, state_dbg.name());
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence + final report ----------------
  initial begin
    fork
      monitor();
    join_none
    do_reset();
    run_instr("add",       32'h002081B3, 0, 0, 1'b0);
    run_instr("sub",       32'h402081B3, 1, 0, 1'b0);
    run_instr("lw_wait3",  32'h0080A283, 0, 3, 1'b0);
    run_instr("beq_taken", 32'h00208463, 0, 0, 1'b1);
    run_instr("beq_not",   32'h00208463, 0, 0, 1'b0);
    run_instr("jal",       32'h010000EF, 0, 0, 1'b0);
    run_instr("sw",        32'h0020A223, 0, 0, 1'b0);
    run_instr("sw_wait",   32'h0020A223, 2, 2, 1'b0);
    run_instr("jalr",      32'h000280E7, 0, 0, 1'b0);
    run_instr("lui",       32'h123452B7, 0, 0, 1'b0);
    run_instr("auipc",     32'h00001297, 1, 0, 1'b0);
    run_instr("srai",      32'h40315093, 0, 0, 1'b0);
    run_instr("addi_b30",  32'h40010093, 0, 0, 1'b0);
    store_reset();
    run_instr("add_after_rst", 32'h002081B3, 0, 0, 1'b0);
    for (int i = 0; i < 60; i++)
      run_instr("random", rand_instr(), $urandom_range(0, 2), $urandom_range(0, 3), rbit());
    run_instr("illegal_7f", 32'h0000007F, 0, 0, 1'b0);
`ifndef ICYRISC_CTRL_TRAP_EN
    run_instr("add_after_nop", 32'h002081B3, 0, 0, 1'b0);
`endif
    do_reset();
    run_instr("add_post_trap", 32'h002081B3, 0, 0, 1'b0);
    run_instr("illegal_low2", 32'h00000010, 0, 0, 1'b0);
`ifndef ICYRISC_CTRL_TRAP_EN
    run_instr("or_after_nop", 32'h0020E1B3, 0, 0, 1'b0);
`endif
    do_reset();
    run_instr("lui_final", 32'h123452B7, 0, 0, 1'b0);
    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
